// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM states, initial hash value and the
// bitwise round/schedule functions.
package sha256_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PRIME,
      S_ROUND,
      S_FINAL
   } state_t;

   // Index 0 is H0.
   localparam logic [31:0] IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
      return (x >> n) | (x << (6'd32 - {1'b0, n}));
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 5'd2) ^ rotr(x, 5'd13) ^ rotr(x, 5'd22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 5'd6) ^ rotr(x, 5'd11) ^ rotr(x, 5'd25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// 16-word message schedule window; slot 0 always presents W[r] and each
// shift appends either a loaded word or the next expanded word.
module sha256_msg_schedule
   import sha256_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        advance,
   input  logic [31:0] w_in,
   output logic [31:0] w_out
);

   logic [31:0] win_q [16];
   logic [31:0] win_d [16];
   logic [31:0] next_word;

   always_comb begin
      win_d     = win_q;
      next_word = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];
      if (load || advance) begin
         for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
         end
         win_d[15] = load ? w_in : next_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         win_q <= win_d;
      end
   end

   assign w_out = win_q[0];

endmodule

// File: rtl/sha256_round_core.sv
// One-round-per-cycle SHA-256 block compressor; round constants are streamed
// in from an external K generator controlled by k_rst_n/k_en.
module sha256_round_core
   import sha256_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         init,
   input  logic         w_valid,
   input  logic [31:0]  w_data,
   output logic         w_ready,
   output logic         k_rst_n,
   output logic         k_en,
   input  logic [31:0]  k_in,
   output logic [255:0] digest,
   output logic         digest_valid,
   output logic         busy
);

   state_t       state_q, state_d;
   logic [3:0]   wcnt_q, wcnt_d;
   logic [5:0]   rcnt_q, rcnt_d;
   logic [31:0]  h_q [8];
   logic [31:0]  h_d [8];
   logic [31:0]  wv_q [8];
   logic [31:0]  wv_d [8];
   logic [255:0] dig_q, dig_d;
   logic         w_ready_q, w_ready_d;
   logic         k_en_q, k_en_d;
   logic         k_rst_n_q, k_rst_n_d;
   logic         dv_q, dv_d;
   logic         sched_load, sched_adv;
   logic [31:0]  w_cur, t1, t2;

   sha256_msg_schedule u_sched (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (sched_load),
      .advance (sched_adv),
      .w_in    (w_data),
      .w_out   (w_cur)
   );

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      rcnt_d     = rcnt_q;
      h_d        = h_q;
      wv_d       = wv_q;
      dig_d      = dig_q;
      w_ready_d  = 1'b0;
      k_en_d     = 1'b0;
      k_rst_n_d  = 1'b1;
      dv_d       = 1'b0;
      sched_load = 1'b0;
      sched_adv  = 1'b0;
      t1 = wv_q[7] + big_sigma1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6]) + k_in + w_cur;
      t2 = big_sigma0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (init) h_d = IV;
               wcnt_d    = '0;
               k_rst_n_d = 1'b0;
               w_ready_d = 1'b1;
               state_d   = S_LOAD;
            end
         end
         S_LOAD: begin
            w_ready_d = 1'b1;
            if (w_valid && w_ready_q) begin
               sched_load = 1'b1;
               wcnt_d     = wcnt_q + 4'd1;
               if (wcnt_q == 4'd15) begin
                  wv_d      = h_q;
                  w_ready_d = 1'b0;
                  k_en_d    = 1'b1;
                  state_d   = S_PRIME;
               end
            end
         end
         S_PRIME: begin
            // Requests K[0] so it is on k_in during round 0.
            k_en_d  = 1'b1;
            rcnt_d  = '0;
            state_d = S_ROUND;
         end
         S_ROUND: begin
            sched_adv = 1'b1;
            wv_d[0] = t1 + t2;
            wv_d[1] = wv_q[0];
            wv_d[2] = wv_q[1];
            wv_d[3] = wv_q[2];
            wv_d[4] = wv_q[3] + t1;
            wv_d[5] = wv_q[4];
            wv_d[6] = wv_q[5];
            wv_d[7] = wv_q[6];
            rcnt_d  = rcnt_q + 6'd1;
            k_en_d  = (rcnt_q < 6'd62);
            if (rcnt_q == 6'd63) state_d = S_FINAL;
         end
         S_FINAL: begin
            for (int i = 0; i < 8; i++) begin
               h_d[i] = h_q[i] + wv_q[i];
               dig_d[255-32*i -: 32] = h_q[i] + wv_q[i];
            end
            dv_d    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         wcnt_q    <= '0;
         rcnt_q    <= '0;
         dig_q     <= '0;
         w_ready_q <= 1'b0;
         k_en_q    <= 1'b0;
         k_rst_n_q <= 1'b0;
         dv_q      <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            h_q[i]  <= '0;
            wv_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         rcnt_q    <= rcnt_d;
         dig_q     <= dig_d;
         w_ready_q <= w_ready_d;
         k_en_q    <= k_en_d;
         k_rst_n_q <= k_rst_n_d;
         dv_q      <= dv_d;
         h_q       <= h_d;
         wv_q      <= wv_d;
      end
   end

   assign w_ready      = w_ready_q;
   assign k_en         = k_en_q;
   assign k_rst_n      = k_rst_n_q;
   assign digest       = dig_q;
   assign digest_valid = dv_q;
   assign busy         = (state_q != S_IDLE);

endmodule
